// File: rtl/decode_execute_reg_pkg.sv
// Shared types for the Decode->Execute pipeline register: control bundle, hold FSM states,
// multi-cycle opcode constants and the multi-cycle detect helper.
package decode_execute_reg_pkg;

    typedef struct packed {
        logic       useScalarAlu;
        logic       isScalarOutput;
        logic       isScalarReg1;
        logic       isScalarReg2;
        logic [1:0] resultSelector;
        logic       writeEnableScalar;
        logic       writeEnableVector;
        logic       writeToMemoryEnable;
        logic       useInmediate;
        logic [3:0] aluControl;
        logic       outFlag;
    } ctrl_t;

    localparam logic [3:0] ALU_DIV = 4'b0110;
    localparam logic [3:0] ALU_MUL = 4'b0111;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } hold_state_e;

    localparam ctrl_t CTRL_BUBBLE = '0;

    // Only scalar-ALU DIV/MUL occupy Execute for more than one cycle.
    function automatic logic is_multicycle(input logic valid, input ctrl_t c);
        return valid & c.useScalarAlu & ((c.aluControl == ALU_DIV) | (c.aluControl == ALU_MUL));
    endfunction

endpackage

// File: rtl/decode_execute_reg_if.sv
// Decode/Execute bundle between the pipeline control and the D->E register.
// Optional IDEX_PERF_CNT_EN adds the issue/bubble performance counters.
interface decode_execute_reg_if
    import decode_execute_reg_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int LANES          = 4,
    parameter int REG_ADDR_WIDTH = 4
);
    logic                        stallE;
    logic                        flushE;
    logic                        validD;
    ctrl_t                       ctrlD;
    logic [DATA_WIDTH-1:0]       opA_D;
    logic [DATA_WIDTH-1:0]       opB_D;
    logic [LANES*DATA_WIDTH-1:0] vecA_D;
    logic [LANES*DATA_WIDTH-1:0] vecB_D;
    logic [DATA_WIDTH-1:0]       immD;
    logic [REG_ADDR_WIDTH-1:0]   rdD;

    ctrl_t                       ctrlE;
    logic [DATA_WIDTH-1:0]       opA_E;
    logic [DATA_WIDTH-1:0]       opB_E;
    logic [LANES*DATA_WIDTH-1:0] vecA_E;
    logic [LANES*DATA_WIDTH-1:0] vecB_E;
    logic [DATA_WIDTH-1:0]       immE;
    logic [REG_ADDR_WIDTH-1:0]   rdE;
    logic                        validE;
    logic                        busyE;
    logic                        opDoneE;

`ifdef IDEX_PERF_CNT_EN
    logic [31:0]                 issueCnt;
    logic [31:0]                 bubbleCnt;

    modport master (
        output stallE, flushE, validD, ctrlD, opA_D, opB_D, vecA_D, vecB_D, immD, rdD,
        input  ctrlE, opA_E, opB_E, vecA_E, vecB_E, immE, rdE, validE, busyE, opDoneE,
        input  issueCnt, bubbleCnt
    );
    modport slave (
        input  stallE, flushE, validD, ctrlD, opA_D, opB_D, vecA_D, vecB_D, immD, rdD,
        output ctrlE, opA_E, opB_E, vecA_E, vecB_E, immE, rdE, validE, busyE, opDoneE,
        output issueCnt, bubbleCnt
    );
`else
    modport master (
        output stallE, flushE, validD, ctrlD, opA_D, opB_D, vecA_D, vecB_D, immD, rdD,
        input  ctrlE, opA_E, opB_E, vecA_E, vecB_E, immE, rdE, validE, busyE, opDoneE
    );
    modport slave (
        input  stallE, flushE, validD, ctrlD, opA_D, opB_D, vecA_D, vecB_D, immD, rdD,
        output ctrlE, opA_E, opB_E, vecA_E, vecB_E, immE, rdE, validE, busyE, opDoneE
    );
`endif

endinterface

// File: rtl/decode_execute_reg_multicycle_ctrl.sv
// Hold FSM for multi-cycle scalar ops: counts the remaining Execute cycles, drives busy
// (upstream stall and E-register hold) and the final-cycle done pulse.
module decode_execute_reg_multicycle_ctrl
    import decode_execute_reg_pkg::*;
#(
    parameter int MULTI_CYCLE_LAT = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic stall_i,
    input  logic flush_i,
    input  logic start_i,
    output logic busy_o,
    output logic op_done_o
);
    localparam int CNT_W = (MULTI_CYCLE_LAT > 1) ? $clog2(MULTI_CYCLE_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MULTI_CYCLE_LAT - 1);

    hold_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_done_o = 1'b0;
        busy_o    = (state_q == HOLD) && (cnt_q != '0);
        if (flush_i) begin
            state_d = RUN;
            cnt_d   = '0;
        end else if (!stall_i) begin
            if (busy_o) begin
                cnt_d = cnt_q - CNT_W'(1);
            end else begin
                // Final hold cycle (or plain RUN): the next instruction loads on this edge.
                op_done_o = (state_q == HOLD);
                if (start_i && (MULTI_CYCLE_LAT > 1)) begin
                    state_d = HOLD;
                    cnt_d   = CNT_INIT;
                end else begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
        end
    end

endmodule

// File: rtl/decode_execute_reg.sv
// Decode->Execute pipeline register with flush bubbles, stall freeze and multi-cycle hold.
// Optional IDEX_PERF_CNT_EN adds issueCnt/bubbleCnt.
module decode_execute_reg
    import decode_execute_reg_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int LANES           = 4,
    parameter int REG_ADDR_WIDTH  = 4,
    parameter int MULTI_CYCLE_LAT = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    decode_execute_reg_if.slave  bus
);
    localparam int VW = LANES * DATA_WIDTH;

    ctrl_t                     ctrl_q, ctrl_d;
    logic                      valid_q, valid_d;
    logic [DATA_WIDTH-1:0]     opa_q, opa_d, opb_q, opb_d, imm_q, imm_d;
    logic [VW-1:0]             veca_q, veca_d, vecb_q, vecb_d;
    logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;

    logic busy;
    logic op_done;
    logic load_en;
    logic load_bubble;

    decode_execute_reg_multicycle_ctrl #(
        .MULTI_CYCLE_LAT (MULTI_CYCLE_LAT)
    ) u_mc (
        .clk       (clk),
        .rst       (rst),
        .stall_i   (bus.stallE),
        .flush_i   (bus.flushE),
        .start_i   (is_multicycle(bus.validD, bus.ctrlD)),
        .busy_o    (busy),
        .op_done_o (op_done)
    );

    assign load_en     = !bus.flushE && !bus.stallE && !busy;
    assign load_bubble = bus.flushE || (load_en && !bus.validD);

    always_comb begin
        ctrl_d  = ctrl_q;
        valid_d = valid_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        veca_d  = veca_q;
        vecb_d  = vecb_q;
        imm_d   = imm_q;
        rd_d    = rd_q;
        if (load_bubble) begin
            ctrl_d  = CTRL_BUBBLE;
            valid_d = 1'b0;
            opa_d   = '0;
            opb_d   = '0;
            veca_d  = '0;
            vecb_d  = '0;
            imm_d   = '0;
            rd_d    = '0;
        end else if (load_en) begin
            ctrl_d  = bus.ctrlD;
            valid_d = 1'b1;
            opa_d   = bus.opA_D;
            opb_d   = bus.opB_D;
            veca_d  = bus.vecA_D;
            vecb_d  = bus.vecB_D;
            imm_d   = bus.immD;
            rd_d    = bus.rdD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q  <= CTRL_BUBBLE;
            valid_q <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            veca_q  <= '0;
            vecb_q  <= '0;
            imm_q   <= '0;
            rd_q    <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            valid_q <= valid_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            veca_q  <= veca_d;
            vecb_q  <= vecb_d;
            imm_q   <= imm_d;
            rd_q    <= rd_d;
        end
    end

    assign bus.ctrlE   = ctrl_q;
    assign bus.validE  = valid_q;
    assign bus.opA_E   = opa_q;
    assign bus.opB_E   = opb_q;
    assign bus.vecA_E  = veca_q;
    assign bus.vecB_E  = vecb_q;
    assign bus.immE    = imm_q;
    assign bus.rdE     = rd_q;
    assign bus.busyE   = busy;
    assign bus.opDoneE = op_done;

`ifdef IDEX_PERF_CNT_EN
    logic [31:0] issue_q, issue_d, bubble_q, bubble_d;

    always_comb begin
        issue_d  = issue_q;
        bubble_d = bubble_q;
        if (load_bubble)  bubble_d = bubble_q + 32'd1;
        else if (load_en) issue_d  = issue_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_q  <= '0;
            bubble_q <= '0;
        end else begin
            issue_q  <= issue_d;
            bubble_q <= bubble_d;
        end
    end

    assign bus.issueCnt  = issue_q;
    assign bus.bubbleCnt = bubble_q;
`endif

endmodule
